arc_regbank: RTL
================

ARC_REGBANK -- requirements
Module: arc_regbank

Interface
REQ-001 Parameter W, default 32, data width of every register and bus.
REQ-002 Parameter R, default 16, number of general registers r0..r(R-1), legal range 2..32.
REQ-003 Parameter T, default 4, number of temporary registers, legal range 1..8.
REQ-004 Parameter AW, default 6, width of every register select field.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 sel_a, sel_b  in  AW  read select for bus A / bus B.
REQ-008 bus_a, bus_b  out  W  selected register contents.
REQ-009 busy_a, busy_b  out  1  selected register awaits a pending load.
REQ-010 wr_en  in  1; wr_sel  in  AW; wr_data  in  W  single-cycle write port (bus C).
REQ-011 ld_req  in  1; ld_sel  in  AW  start a memory load into ld_sel.
REQ-012 ld_valid  in  1; ld_data  in  W  memory return data, one-cycle strobe.
REQ-013 ld_busy  out  1  a load is outstanding; ld_ovf  out  1  one-cycle pulse, rejected ld_req.
REQ-014 cc_en  in  1; flags  in  4  {n,z,v,c} from ALU; psr  out  4  registered flags.
REQ-015 pc  out  W; ir  out  W  direct views of PC and IR.

Function
REQ-016 Address map: 0..R-1 general, 32 PC, 33..32+T temporaries, 33+T IR; all other codes unmapped.
REQ-017 Reads of r0 and unmapped codes SHALL return 0; writes to them SHALL be discarded.
REQ-018 bus_a/bus_b SHALL be combinational from sel and register state; a write becomes visible the cycle after its edge (no bypass).
REQ-019 wr_en=1 SHALL write wr_data to wr_sel on the edge.
REQ-020 Load FSM states IDLE and WAIT; IDLE->WAIT on ld_req, latching ld_sel as target.
REQ-021 WAIT->IDLE on ld_valid, writing ld_data to target on that edge; ld_valid in IDLE ignored.
REQ-022 ld_req in WAIT SHALL be ignored and SHALL pulse ld_ovf next cycle; ld_req with ld_valid in WAIT is also rejected.
REQ-023 ld_busy SHALL be 1 exactly while in WAIT.
REQ-024 busy_a (busy_b) SHALL be 1 iff in WAIT, target mapped and nonzero, and sel_a (sel_b) equals target.
REQ-025 Load to r0 or unmapped code SHALL run the FSM normally with no register write and no busy_a/busy_b.
REQ-026 wr_en and load completion on the same edge to different registers SHALL both take effect; to the same register the load data SHALL win.
REQ-027 wr_en to the current load target during WAIT SHALL write normally; the later load completion overwrites it.
REQ-028 cc_en=1 SHALL load flags into psr on the edge; otherwise psr holds.
REQ-029 Register select width AW SHALL cover 33+T; codes are compared at full AW width, no wrap.

Reset
REQ-030 rst=0 on an edge SHALL clear all registers, PC, IR, temporaries and psr to 0.
REQ-031 rst=0 SHALL force FSM to IDLE, ld_busy=0, ld_ovf=0, discarding any pending load; ld_valid in the reset cycle is ignored.
REQ-032 rst SHALL take priority over wr_en, ld_req, ld_valid and cc_en in the same cycle.

Verification
REQ-033 Reset, then sel_a=5, sel_b=32 -> bus_a=0, bus_b=0, psr=0, ld_busy=0.
REQ-034 wr_en, wr_sel=3, wr_data=0xDEADBEEF; next cycle sel_a=3 -> bus_a=0xDEADBEEF; wr_sel=0 data 0x1234 -> bus_a(sel 0)=0.
REQ-035 ld_req sel=34 (temp1); sel_b=34 -> busy_b=1 for 3 cycles; ld_valid data 0xCAFE0001 -> ld_busy=0 next cycle, bus_b=0xCAFE0001.
REQ-036 In WAIT issue ld_req sel=7 -> ld_ovf pulses once, target unchanged, r7 unchanged after completion.
REQ-037 ld_valid and wr_en both to r4 same edge (0x11 vs 0x22) -> r4=0x11; to r4/r5 -> r4=0x11, r5=0x22.
REQ-038 ld_req then rst=0 before ld_valid; late ld_valid 0x55 -> target remains 0, ld_busy=0; cc_en with flags=0xA -> psr=0xA next cycle.

Source files
------------

// File: rtl/arc_regbank_if.sv
// arc_regbank bus bundle: read ports A/B, write port C,
// memory load handshake, condition codes and PC/IR views.
interface arc_regbank_if #(
  parameter int W  = 32,
  parameter int AW = 6
);
  logic [AW-1:0] sel_a;
  logic [AW-1:0] sel_b;
  logic [W-1:0]  bus_a;
  logic [W-1:0]  bus_b;
  logic          busy_a;
  logic          busy_b;
  logic          wr_en;
  logic [AW-1:0] wr_sel;
  logic [W-1:0]  wr_data;
  logic          ld_req;
  logic [AW-1:0] ld_sel;
  logic          ld_valid;
  logic [W-1:0]  ld_data;
  logic          ld_busy;
  logic          ld_ovf;
  logic          cc_en;
  logic [3:0]    flags;
  logic [3:0]    psr;
  logic [W-1:0]  pc;
  logic [W-1:0]  ir;

  modport master (
    output sel_a, sel_b, wr_en, wr_sel, wr_data,
    output ld_req, ld_sel, ld_valid, ld_data,
    output cc_en, flags,
    input  bus_a, bus_b, busy_a, busy_b,
    input  ld_busy, ld_ovf, psr, pc, ir
  );

  modport slave (
    input  sel_a, sel_b, wr_en, wr_sel, wr_data,
    input  ld_req, ld_sel, ld_valid, ld_data,
    input  cc_en, flags,
    output bus_a, bus_b, busy_a, busy_b,
    output ld_busy, ld_ovf, psr, pc, ir
  );
endinterface

// File: rtl/arc_regbank.sv
// Register bank: general regs, PC, temporaries and IR behind one
// select space, with a single outstanding memory load tracker.
module arc_regbank #(
  parameter int W  = 32,
  parameter int R  = 16,
  parameter int T  = 4,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  arc_regbank_if.slave  b
);

  // Storage order: r0..r(R-1), PC, temps, IR.
  // Codes 32.. map contiguously onto R.. so one offset covers them.
  localparam int N  = R + T + 2;
  localparam int IW = $clog2(N);

  typedef enum logic {S_IDLE, S_WAIT} ld_st_t;

  ld_st_t        state;
  ld_st_t        nstate;
  logic [AW-1:0] tgt;
  logic          ovf_q;
  logic [3:0]    psr_q;
  logic [W-1:0]  rf [N];
  logic          ld_done;

  function automatic logic live(input logic [AW-1:0] s);
    live = (s != '0) &&
           ((s < AW'(R)) ||
            ((s >= AW'(32)) && (s <= AW'(33 + T))));
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] s);
    if (s < AW'(R))
      idx = IW'(s);
    else
      idx = IW'(s - AW'(32) + AW'(R));
  endfunction

  assign ld_done = (state == S_WAIT) && b.ld_valid;

  // Load tracker next state: one load in flight at a time.
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: if (b.ld_req)   nstate = S_WAIT;
      S_WAIT: if (b.ld_valid) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Load tracker state, latched target and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      tgt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= nstate;
      ovf_q <= (state == S_WAIT) && b.ld_req;
      if ((state == S_IDLE) && b.ld_req)
        tgt <= b.ld_sel;
    end
  end

  // Register file writes; load data is applied last so it wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++)
        rf[i] <= '0;
    end else begin
      if (b.wr_en && live(b.wr_sel))
        rf[idx(b.wr_sel)] <= b.wr_data;
      if (ld_done && live(tgt))
        rf[idx(tgt)] <= b.ld_data;
    end
  end

  // Condition code register.
  always_ff @(posedge clk) begin
    if (!rst)
      psr_q <= '0;
    else if (b.cc_en)
      psr_q <= b.flags;
  end

  assign b.bus_a   = live(b.sel_a) ? rf[idx(b.sel_a)] : '0;
  assign b.bus_b   = live(b.sel_b) ? rf[idx(b.sel_b)] : '0;
  assign b.busy_a  = (state == S_WAIT) && live(tgt) &&
                     (b.sel_a == tgt);
  assign b.busy_b  = (state == S_WAIT) && live(tgt) &&
                     (b.sel_b == tgt);
  assign b.ld_busy = (state == S_WAIT);
  assign b.ld_ovf  = ovf_q;
  assign b.psr     = psr_q;
  assign b.pc      = rf[R];
  assign b.ir      = rf[R + T + 1];

endmodule
